rf_write_arbiter: RTL and testbench
===================================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width.
REQ-002 SHALL have parameter NREGS, default 32, architectural register count; the index width is 5.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports alu_valid/alu_rd/alu_data  input  1/5/XLEN  ALU writeback request.
REQ-006 SHALL have port alu_ready  output  1  ALU request accepted this cycle.
REQ-007 SHALL have ports lsu_valid/lsu_rd/lsu_data  input  1/5/XLEN  load writeback request.
REQ-008 SHALL have port lsu_ready  output  1  LSU request accepted this cycle.
REQ-009 SHALL have ports issue_valid/issue_rd  input  1/5  a decoded instruction that will write issue_rd.
REQ-010 SHALL have ports rs1/rs2  input  5/5  source registers of the instruction in decode.
REQ-011 SHALL have ports hazard1/hazard2  output  1/1  combinational; the source has a pending write.
REQ-012 SHALL have ports WE3/WA3/WD3  output  1/5/XLEN  registered drive of the register-file write port.
REQ-013 SHALL have port stall_cnt  output  16  saturating count of cycles in which a valid requester was refused.

Function
REQ-014 SHALL accept a request only when valid and ready are both high in the same cycle.
REQ-015 SHALL accept at most one request per cycle; ready is combinational from the valid inputs and the arbitration state.
REQ-016 SHALL treat a refused requester as holding valid, rd and data stable until accepted; the arbiter does not check this.
REQ-017 SHALL, for a request accepted in cycle N, drive WE3=1 with WA3=rd and WD3=data in cycle N+1 only, so the register file is written at the end of N+1.
REQ-018 SHALL accept a request with rd=0 normally (ready=1) but hold WE3=0 in N+1.
REQ-019 SHALL drive WE3=0 in any cycle that follows a cycle with no acceptance; WA3/WD3 then hold their last values.
REQ-020 SHALL keep a pending mask of NREGS bits; issue_valid with issue_rd!=0 sets pending[issue_rd].
REQ-021 SHALL clear pending[WA3] at the rising edge that ends a cycle with WE3=1.
REQ-022 SHALL give set priority when a set and a clear target the same index in the same cycle.
REQ-023 SHALL compute hazardN = pending[rsN] when rsN!=0, else 0; pending[0] is never set.
REQ-024 SHALL increment stall_cnt once per cycle in which any valid requester is not ready, and saturate it at 16'hFFFF.

Reset
REQ-025 SHALL, while rst is high at a clock edge, clear the pending mask, WE3, WA3, WD3 and stall_cnt to 0, and set the last-grant pointer to LSU.
REQ-026 SHALL hold alu_ready and lsu_ready at 0 during any cycle in which rst is high.
REQ-027 SHALL drop an acceptance that is in flight when reset arrives: WE3=0 in the cycle after reset.

Configuration
REQ-028 SHALL, with RF_ARB_ROUND_ROBIN_EN defined and both requesters valid, grant the requester not granted last; the pointer updates only on an acceptance.
REQ-029 SHALL, without RF_ARB_ROUND_ROBIN_EN, always grant LSU when both requesters are valid; no pointer register is built.
REQ-030 SHALL, with only one requester valid, grant it regardless of RF_ARB_ROUND_ROBIN_EN.

Structure
REQ-031 SHALL take XLEN, the reg_idx_t typedef (5 bits) and the req_src_t enum {SRC_ALU, SRC_LSU} from the shared package rx32_pkg.
REQ-032 SHALL implement the pending mask and hazard lookup in the sub-module rf_scoreboard.

Verification
REQ-033 SHALL check: alu_valid, rd=5, data=32'hDEADBEEF in cycle N -> alu_ready=1 in N; WE3=1, WA3=5, WD3=32'hDEADBEEF in N+1.
REQ-034 SHALL check: ALU rd=3 and LSU rd=4 both valid for 2 cycles -> with the macro, grants are ALU then LSU; without it, LSU then ALU; stall_cnt=1 after.
REQ-035 SHALL check: issue_valid with issue_rd=7, then rs1=7 -> hazard1=1 until the cycle after WE3=1 with WA3=7, then 0.
REQ-036 SHALL check: LSU write to rd=0 -> lsu_ready=1, WE3=0 next cycle; issue_rd=0 -> hazard1=0 for rs1=0.
REQ-037 SHALL check: issue_rd=9 set in the same cycle as WE3=1 with WA3=9 -> pending[9] remains 1.
REQ-038 SHALL check: rst asserted the cycle after an acceptance -> WE3=0 and stall_cnt=0; all hazards read 0.

Source files
------------

// File: rtl/rx32_pkg.sv
// Shared types for the rx32 register-file write path.
package rx32_pkg;

  localparam int XLEN = 32;

  typedef logic [4:0] reg_idx_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } req_src_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write mask with combinational hazard lookup for two source operands.
// Register 0 is never marked pending. A set wins over a clear to the same index.
module rf_scoreboard
  import rx32_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_valid_i,
  input  logic [4:0] set_idx_i,
  input  logic       clr_valid_i,
  input  logic [4:0] clr_idx_i,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  output logic       hazard1_o,
  output logic       hazard2_o
);

  logic [NREGS-1:0] pending_q, pending_d;

  // Next mask: apply the writeback clear first so a same-cycle set overrides it.
  always_comb begin
    pending_d = pending_q;
    for (int i = 1; i < NREGS; i++) begin
      if (clr_valid_i && (clr_idx_i == reg_idx_t'(i))) pending_d[i] = 1'b0;
      if (set_valid_i && (set_idx_i == reg_idx_t'(i))) pending_d[i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Mask register.
  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  assign hazard1_o = (rs1_i != '0) && pending_q[rs1_i];
  assign hazard2_o = (rs2_i != '0) && pending_q[rs2_i];

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates ALU and LSU writebacks onto the single register-file write port,
// tracks pending destinations for decode hazards, and counts refused cycles.
// Optional macro RF_ARB_ROUND_ROBIN_EN: alternate grants on contention;
// otherwise LSU always wins.
module rf_write_arbiter
  import rx32_pkg::*;
#(
  parameter int XLEN  = rx32_pkg::XLEN,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            hazard1,
  output logic            hazard2,
  output logic            WE3,
  output logic [4:0]      WA3,
  output logic [XLEN-1:0] WD3,
  output logic [15:0]     stall_cnt
);

  req_src_t        grant_src;
  logic            accept, refused;
  reg_idx_t        sel_rd;
  logic [XLEN-1:0] sel_data;

  logic            we_q, we_d;
  reg_idx_t        wa_q, wa_d;
  logic [XLEN-1:0] wd_q, wd_d;
  logic [15:0]     stall_q, stall_d;

`ifdef RF_ARB_ROUND_ROBIN_EN
  req_src_t last_q, last_d;
`endif

  // Grant selection; nothing is accepted while reset is asserted.
  always_comb begin
    grant_src = SRC_LSU;
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (!rst) begin
      if (alu_valid && lsu_valid) begin
`ifdef RF_ARB_ROUND_ROBIN_EN
        grant_src = (last_q == SRC_LSU) ? SRC_ALU : SRC_LSU;
`else
        grant_src = SRC_LSU;
`endif
      end else if (alu_valid) begin
        grant_src = SRC_ALU;
      end
      alu_ready = alu_valid && (grant_src == SRC_ALU);
      lsu_ready = lsu_valid && (grant_src == SRC_LSU);
    end
  end

  assign accept   = (alu_valid && alu_ready) || (lsu_valid && lsu_ready);
  assign refused  = (alu_valid && !alu_ready) || (lsu_valid && !lsu_ready);
  assign sel_rd   = (grant_src == SRC_ALU) ? alu_rd : lsu_rd;
  assign sel_data = (grant_src == SRC_ALU) ? alu_data : lsu_data;

  // Write-port next state: an accepted x0 write still updates WA3/WD3 but never strobes WE3.
  always_comb begin
    we_d    = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    stall_d = stall_q;
    if (accept) begin
      we_d = (sel_rd != '0);
      wa_d = sel_rd;
      wd_d = sel_data;
    end
    if (refused && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  // Write-port and stall-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      stall_q <= '0;
    end else begin
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      stall_q <= stall_d;
    end
  end

`ifdef RF_ARB_ROUND_ROBIN_EN
  assign last_d = accept ? grant_src : last_q;

  // Last-grant pointer; moves only when a request is actually taken.
  always_ff @(posedge clk) begin
    if (rst) last_q <= SRC_LSU;
    else     last_q <= last_d;
  end
`endif

  rf_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk         (clk),
    .rst         (rst),
    .set_valid_i (issue_valid && (issue_rd != '0)),
    .set_idx_i   (issue_rd),
    .clr_valid_i (we_q),
    .clr_idx_i   (wa_q),
    .rs1_i       (rs1),
    .rs2_i       (rs2),
    .hazard1_o   (hazard1),
    .hazard2_o   (hazard2)
  );

  assign WE3       = we_q;
  assign WA3       = wa_q;
  assign WD3       = wd_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter. A cycle model predicts readies,
// hazards and the stall count; predicted write-port values are queued when a
// request is driven and compared when the registered port should show them.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lsu_valid, issue_valid;
  logic [4:0]  alu_rd, lsu_rd, issue_rd, rs1, rs2;
  logic [31:0] alu_data, lsu_data;
  logic        alu_ready, lsu_ready, hazard1, hazard2, WE3;
  logic [4:0]  WA3;
  logic [31:0] WD3;
  logic [15:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
  } wr_t;
  wr_t q[$];

  // model state
  logic [31:0] pend_m;
  logic        last_lsu_m;
  int          stall_m;
  logic        we_m;
  logic [4:0]  wa_m;
  logic [31:0] wd_m;

  rf_write_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
    .hazard1(hazard1), .hazard2(hazard2),
    .WE3(WE3), .WA3(WA3), .WD3(WD3), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic idle();
    alu_valid = 0; lsu_valid = 0; issue_valid = 0;
    alu_rd = 0; lsu_rd = 0; issue_rd = 0; alu_data = 0; lsu_data = 0;
  endtask

  // One clock cycle: inputs already driven; check combinational outputs mid-cycle,
  // advance the model, then check registered outputs just after the edge.
  task automatic step();
    logic ea, el, h1, h2;
    wr_t  e;
    ea = 0; el = 0;
    if (!rst) begin
      if (alu_valid && lsu_valid) begin
`ifdef RF_ARB_ROUND_ROBIN_EN
        if (last_lsu_m) ea = 1; else el = 1;
`else
        el = 1;
`endif
      end else begin
        ea = alu_valid; el = lsu_valid;
      end
    end
    h1 = (rs1 != 0) && pend_m[rs1];
    h2 = (rs2 != 0) && pend_m[rs2];
    @(negedge clk);
    total++; if (alu_ready !== ea) begin bad++; $display("FAIL alu_ready got=%b exp=%b t=%0t", alu_ready, ea, $time); end
    total++; if (lsu_ready !== el) begin bad++; $display("FAIL lsu_ready got=%b exp=%b t=%0t", lsu_ready, el, $time); end
    total++; if (hazard1 !== h1) begin bad++; $display("FAIL hazard1 got=%b exp=%b t=%0t", hazard1, h1, $time); end
    total++; if (hazard2 !== h2) begin bad++; $display("FAIL hazard2 got=%b exp=%b t=%0t", hazard2, h2, $time); end
    if (rst) begin
      q.push_back('{1'b0, 5'd0, 32'd0});
    end else if (ea) begin
      q.push_back('{alu_rd != 0, alu_rd, alu_data}); last_lsu_m = 0;
    end else if (el) begin
      q.push_back('{lsu_rd != 0, lsu_rd, lsu_data}); last_lsu_m = 1;
    end else begin
      q.push_back('{1'b0, wa_m, wd_m});
    end
    if (rst) begin
      stall_m = 0; pend_m = 0; last_lsu_m = 1;
    end else begin
      if (((alu_valid && !ea) || (lsu_valid && !el)) && stall_m < 65535) stall_m++;
      if (we_m) pend_m[wa_m] = 1'b0;
      if (issue_valid && issue_rd != 0) pend_m[issue_rd] = 1'b1;
    end
    @(posedge clk); #1;
    e = q.pop_front();
    we_m = e.we; wa_m = e.wa; wd_m = e.wd;
    total++; if (WE3 !== we_m) begin bad++; $display("FAIL WE3 got=%b exp=%b t=%0t", WE3, we_m, $time); end
    total++; if (WA3 !== wa_m) begin bad++; $display("FAIL WA3 got=%0d exp=%0d t=%0t", WA3, wa_m, $time); end
    total++; if (WD3 !== wd_m) begin bad++; $display("FAIL WD3 got=%h exp=%h t=%0t", WD3, wd_m, $time); end
    total++; if (stall_cnt !== 16'(stall_m)) begin bad++; $display("FAIL stall_cnt got=%0d exp=%0d t=%0t", stall_cnt, stall_m, $time); end
  endtask

  task automatic test_reset();
    idle(); rs1 = 0; rs2 = 0;
    rst = 1; step();
    rst = 0; step();
    total++; if (stall_cnt !== 16'd0 || WE3 !== 1'b0) begin bad++; $display("FAIL reset_state stall=%0d we=%b exp 0/0", stall_cnt, WE3); end
  endtask

  task automatic test_single_alu();
    idle(); alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    step();
    total++; if (WE3 !== 1'b1 || WA3 !== 5'd5 || WD3 !== 32'hDEADBEEF) begin
      bad++; $display("FAIL alu_write we=%b wa=%0d wd=%h exp 1/5/deadbeef", WE3, WA3, WD3); end
    idle(); step();
    total++; if (WE3 !== 1'b0 || WD3 !== 32'hDEADBEEF) begin
      bad++; $display("FAIL alu_hold we=%b wd=%h exp 0/deadbeef", WE3, WD3); end
  endtask

  task automatic test_arbitration();
    idle(); rst = 1; step(); rst = 0;
    alu_valid = 1; alu_rd = 3; alu_data = 32'h0000_0A1A;
    lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h0000_05C5;
    step();
`ifdef RF_ARB_ROUND_ROBIN_EN
    total++; if (WA3 !== 5'd3) begin bad++; $display("FAIL arb_first got=%0d exp=3", WA3); end
    alu_valid = 0;
`else
    total++; if (WA3 !== 5'd4) begin bad++; $display("FAIL arb_first got=%0d exp=4", WA3); end
    lsu_valid = 0;
`endif
    step();
`ifdef RF_ARB_ROUND_ROBIN_EN
    total++; if (WA3 !== 5'd4) begin bad++; $display("FAIL arb_second got=%0d exp=4", WA3); end
`else
    total++; if (WA3 !== 5'd3) begin bad++; $display("FAIL arb_second got=%0d exp=3", WA3); end
`endif
    idle(); step();
    total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL arb_stall got=%0d exp=1", stall_cnt); end
  endtask

  task automatic test_hazard();
    idle(); issue_valid = 1; issue_rd = 7; step();
    idle(); rs1 = 7; step(); step();
    alu_valid = 1; alu_rd = 7; alu_data = 32'h7777_0007; step();   // accepted
    idle(); step();                                                 // WE3=1, WA3=7
    total++; if (hazard1 !== 1'b0) begin bad++; $display("FAIL hazard_clear got=%b exp=0", hazard1); end
    step();
  endtask

  task automatic test_rd_zero();
    idle(); lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h1234_5678; step();
    total++; if (WE3 !== 1'b0) begin bad++; $display("FAIL rd0_we got=%b exp=0", WE3); end
    idle(); issue_valid = 1; issue_rd = 0; step();
    idle(); rs1 = 0; step();
    total++; if (hazard1 !== 1'b0) begin bad++; $display("FAIL rd0_hazard got=%b exp=0", hazard1); end
  endtask

  task automatic test_set_clear_same();
    idle(); alu_valid = 1; alu_rd = 9; alu_data = 32'h9; step();
    idle(); issue_valid = 1; issue_rd = 9; step();                  // WE3=1 WA3=9 this cycle
    idle(); rs1 = 9; step();
    total++; if (hazard1 !== 1'b1) begin bad++; $display("FAIL set_over_clear got=%b exp=1", hazard1); end
    rs1 = 0; step();
  endtask

  task automatic test_reset_inflight();
    idle(); issue_valid = 1; issue_rd = 12; step();
    idle(); lsu_valid = 1; lsu_rd = 11; lsu_data = 32'hBAD0_0011; step();
    idle(); rst = 1; step();
    total++; if (WE3 !== 1'b0 || stall_cnt !== 16'd0) begin
      bad++; $display("FAIL rst_inflight we=%b stall=%0d exp 0/0", WE3, stall_cnt); end
    rst = 0; rs1 = 12; rs2 = 11; step();
    total++; if (hazard1 !== 1'b0 || hazard2 !== 1'b0) begin
      bad++; $display("FAIL rst_hazards h1=%b h2=%b exp 0/0", hazard1, hazard2); end
    rs1 = 0; rs2 = 0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      alu_valid   = 1'($urandom_range(0, 1));
      lsu_valid   = 1'($urandom_range(0, 1));
      alu_rd      = 5'($urandom_range(0, 31));
      lsu_rd      = 5'($urandom_range(0, 31));
      alu_data    = $urandom;
      lsu_data    = $urandom;
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd    = 5'($urandom_range(0, 31));
      rs1         = 5'($urandom_range(0, 31));
      rs2         = 5'($urandom_range(0, 31));
      step();
    end
    idle(); step();
  endtask

  initial begin
    idle(); rs1 = 0; rs2 = 0; rst = 1;
    @(posedge clk); #1;
    pend_m = 0; last_lsu_m = 1; stall_m = 0; we_m = 0; wa_m = 0; wd_m = 0;
    test_reset();
    test_single_alu();
    test_arbitration();
    test_hazard();
    test_rd_zero();
    test_set_clear_same();
    test_reset_inflight();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
